// File: rtl/sfq_stream_pkg.sv
// Shared types and width helpers for the SFQ stream deserialiser slice.
package sfq_stream_pkg;

    // Framing state: IDLE waits for the first frame strobe, COLLECT assembles words.
    typedef enum logic [0:0] {
        IDLE    = 1'b0,
        COLLECT = 1'b1
    } state_t;

    localparam int W_DEF     = 8;
    localparam int DEPTH_DEF = 2;
    localparam int CW_DEF    = $clog2(W_DEF);

    // Bit-counter width needed to index a W-bit word.
    function automatic int cnt_width(input int w);
        return $clog2(w);
    endfunction

    // FIFO occupancy width: one extra bit so that full and empty differ.
    function automatic int fifo_cnt_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/abo_deser_buf_if.sv
// Readout/stream interface of abo_deser_buf: ABO bit input, frame strobe,
// valid/ready word output and status flags.
interface abo_deser_buf_if #(
    parameter int W = 8
) ();
    logic         ABI;
    logic         FI;
    logic         DRI;
    logic [W-1:0] DO;
    logic         DVO;
    logic         OVO;
    logic         FEO;
    logic         SYO;

    modport master (
        output ABI, FI, DRI,
        input  DO, DVO, OVO, FEO, SYO
    );

    modport slave (
        input  ABI, FI, DRI,
        output DO, DVO, OVO, FEO, SYO
    );
endinterface

// File: rtl/abo_deser_buf_fifo.sv
// Small synchronous first-word-fall-through FIFO with registered head outputs.
module abo_fifo
    import sfq_stream_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic         TI,
    input  logic         RI,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] DO,
    output logic         DVO,
    output logic         full
);
    localparam int AW  = $clog2(DEPTH);
    localparam int CNW = fifo_cnt_width(DEPTH);

    logic [W-1:0]   mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CNW-1:0] count_r;
    logic [W-1:0]   do_r;
    logic           dvo_r;

    logic           pop_ok_s;
    logic           push_ok_s;
    logic [AW-1:0]  next_rd_s;
    logic [CNW-1:0] next_count_s;
    logic [W-1:0]   head_s;
    logic           bypass_s;

    assign full = (count_r == CNW'(DEPTH));
    assign DO   = do_r;
    assign DVO  = dvo_r;

    // Accept/advance decisions and the head word visible after this edge.
    always_comb begin
        pop_ok_s     = pop & dvo_r;
        push_ok_s    = push & (~full | pop_ok_s);
        next_rd_s    = rd_ptr_r;
        next_count_s = count_r;
        if (pop_ok_s) begin
            next_rd_s = rd_ptr_r + AW'(1);
        end else begin
            next_rd_s = rd_ptr_r;
        end
        case ({push_ok_s, pop_ok_s})
            2'b10:   next_count_s = count_r + CNW'(1);
            2'b01:   next_count_s = count_r - CNW'(1);
            default: next_count_s = count_r;
        endcase
        // The incoming word becomes the head only when nothing older remains.
        bypass_s = push_ok_s & ((count_r == CNW'(0)) |
                                (pop_ok_s & (count_r == CNW'(1))));
        if (bypass_s) begin
            head_s = din;
        end else begin
            head_s = mem_r[next_rd_s];
        end
    end

    // Storage, pointers, occupancy and registered head word/valid.
    always_ff @(posedge TI) begin
        if (RI) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
            do_r     <= '0;
            dvo_r    <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= din;
                wr_ptr_r        <= wr_ptr_r + AW'(1);
            end
            rd_ptr_r <= next_rd_s;
            count_r  <= next_count_s;
            dvo_r    <= (next_count_s != CNW'(0));
            if (next_count_s != CNW'(0)) begin
                do_r <= head_s;
            end
        end
    end
endmodule

// File: rtl/abo_deser_buf.sv
// Deserialises the ABO pulse stream into W-bit words (LSB first) framed by FI,
// buffers them in an FWFT FIFO and flags overflow and framing errors.
module abo_deser_buf
    import sfq_stream_pkg::*;
#(
    parameter int W     = 8,
    parameter int DEPTH = 2
) (
    input  logic            TI,
    input  logic            RI,
    abo_deser_buf_if.slave  bus
);
    localparam int CW = cnt_width(W);

    state_t          state_r;
    logic [CW-1:0]   cnt_r;
    logic [W-1:0]    shreg_r;
    logic            ovo_r;
    logic            feo_r;
    logic            syo_r;

    logic            last_bit_s;
    logic            push_s;
    logic            pop_s;
    logic            overflow_s;
    logic [W-1:0]    word_s;
    logic [W-1:0]    fifo_do_s;
    logic            fifo_dvo_s;
    logic            fifo_full_s;

    // Word under assembly with the current bit inserted, and FIFO push/pop intent.
    always_comb begin
        word_s         = shreg_r;
        word_s[cnt_r]  = bus.ABI;
        last_bit_s     = (cnt_r == CW'(W - 1));
        // A frame strobe on the final bit aborts the word instead of completing it.
        push_s         = (state_r == COLLECT) & ~bus.FI & last_bit_s;
        pop_s          = fifo_dvo_s & bus.DRI;
        overflow_s     = push_s & fifo_full_s & ~pop_s;
    end

    // Framing FSM, shift register and sticky status flags.
    always_ff @(posedge TI) begin
        if (RI) begin
            state_r <= IDLE;
            cnt_r   <= '0;
            shreg_r <= '0;
            ovo_r   <= 1'b0;
            feo_r   <= 1'b0;
            syo_r   <= 1'b0;
        end else begin
            if (overflow_s) begin
                ovo_r <= 1'b1;
            end
            case (state_r)
                IDLE: begin
                    if (bus.FI) begin
                        shreg_r <= {{(W-1){1'b0}}, bus.ABI};
                        cnt_r   <= CW'(1);
                        state_r <= COLLECT;
                        syo_r   <= 1'b1;
                    end
                end
                COLLECT: begin
                    if (bus.FI) begin
                        if (cnt_r != CW'(0)) begin
                            feo_r <= 1'b1;
                        end
                        shreg_r <= {{(W-1){1'b0}}, bus.ABI};
                        cnt_r   <= CW'(1);
                    end else if (last_bit_s) begin
                        shreg_r <= '0;
                        cnt_r   <= '0;
                    end else begin
                        shreg_r <= word_s;
                        cnt_r   <= cnt_r + CW'(1);
                    end
                    syo_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    cnt_r   <= '0;
                    syo_r   <= 1'b0;
                end
            endcase
        end
    end

    abo_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .TI   (TI),
        .RI   (RI),
        .push (push_s),
        .pop  (pop_s),
        .din  (word_s),
        .DO   (fifo_do_s),
        .DVO  (fifo_dvo_s),
        .full (fifo_full_s)
    );

    assign bus.DO  = fifo_do_s;
    assign bus.DVO = fifo_dvo_s;
    assign bus.OVO = ovo_r;
    assign bus.FEO = feo_r;
    assign bus.SYO = syo_r;
endmodule

// File: tb/tb_abo_deser_buf.sv
// Self-checking bench for abo_deser_buf (W=4, DEPTH=2): directed scenarios plus
// randomized traffic compared every cycle against a queue-based reference model.
module tb_abo_deser_buf;
    localparam int W     = 4;
    localparam int DEPTH = 2;

    logic TI;
    logic RI;

    abo_deser_buf_if #(.W(W)) bus ();

    abo_deser_buf #(
        .W     (W),
        .DEPTH (DEPTH)
    ) dut (
        .TI  (TI),
        .RI  (RI),
        .bus (bus)
    );

    initial TI = 1'b0;
    always #5 TI = ~TI;

    int total = 0;
    int bad   = 0;

    // Reference model: framing status, partial word and buffered words.
    bit m_coll;
    int m_n;
    int m_val;
    int m_q[$];
    bit m_ovo;
    bit m_feo;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_step(input bit ri, input bit fi, input bit abi, input bit dri);
        bit do_pop;
        bit have;
        int pre;
        int w;
        if (ri) begin
            m_coll = 1'b0;
            m_n    = 0;
            m_val  = 0;
            m_ovo  = 1'b0;
            m_feo  = 1'b0;
            m_q.delete();
        end else begin
            do_pop = (m_q.size() > 0) && dri;
            pre    = m_q.size();
            have   = 1'b0;
            w      = 0;
            if (fi) begin
                if (m_coll && m_n != 0) m_feo = 1'b1;
                m_coll = 1'b1;
                m_n    = 1;
                m_val  = int'(abi);
            end else if (m_coll) begin
                m_val = m_val + (int'(abi) << m_n);
                m_n++;
                if (m_n == W) begin
                    have  = 1'b1;
                    w     = m_val;
                    m_n   = 0;
                    m_val = 0;
                end
            end
            if (do_pop) void'(m_q.pop_front());
            if (have) begin
                if (pre == DEPTH && !do_pop) m_ovo = 1'b1;
                else m_q.push_back(w);
            end
        end
    endtask

    // One clock: drive inputs, advance model at the edge, compare on the falling edge.
    task automatic cyc(input bit ri, input bit fi, input bit abi, input bit dri);
        RI      = ri;
        bus.FI  = fi;
        bus.ABI = abi;
        bus.DRI = dri;
        @(posedge TI);
        model_step(ri, fi, abi, dri);
        @(negedge TI);
        chk("dvo", 32'(bus.DVO), 32'(m_q.size() > 0));
        if (m_q.size() > 0) chk("do", 32'(bus.DO), 32'(m_q[0]));
        chk("ovo", 32'(bus.OVO), 32'(m_ovo));
        chk("feo", 32'(bus.FEO), 32'(m_feo));
        chk("syo", 32'(bus.SYO), 32'(m_coll));
    endtask

    // Send one word LSB first; FI on the first bit only when asked.
    task automatic send_word(input logic [3:0] wd, input bit first_fi, input bit dri, input bit dri_last);
        logic [3:0] v;
        v = wd;
        for (int i = 0; i < W; i++) begin
            cyc(1'b0, (i == 0) && first_fi, v[i], (i == W - 1) ? dri_last : dri);
        end
    endtask

    initial begin
        logic [7:0] bits8;
        RI = 1'b1; bus.FI = 1'b0; bus.ABI = 1'b0; bus.DRI = 1'b0;
        @(negedge TI);

        // Reset state.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        chk("rst_dvo", 32'(bus.DVO), 32'd0);
        chk("rst_ovo", 32'(bus.OVO), 32'd0);
        chk("rst_syo", 32'(bus.SYO), 32'd0);

        // Single framed word 4'b1101, popped the cycle it appears.
        send_word(4'hD, 1'b1, 1'b1, 1'b1);
        chk("tp1_dvo", 32'(bus.DVO), 32'd1);
        chk("tp1_do", 32'(bus.DO), 32'hD);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("tp1_ovo", 32'(bus.OVO), 32'd0);
        chk("tp1_feo", 32'(bus.FEO), 32'd0);

        // Contiguous stream after a single FI: words 1 then E.
        cyc(1'b1, 1'b0, 1'b0, 1'b1);
        bits8 = 8'b1110_0001;
        for (int i = 0; i < 8; i++) begin
            cyc(1'b0, i == 0, bits8[i], 1'b1);
            if (i == 3) chk("tp2_w0", 32'(bus.DO), 32'h1);
            if (i == 7) chk("tp2_w1", 32'(bus.DO), 32'hE);
            chk("tp2_syo", 32'(bus.SYO), 32'd1);
        end

        // Backpressure: 3, 5, 9 with DRI low; 9 is dropped.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(4'h3, 1'b1, 1'b0, 1'b0);
        send_word(4'h5, 1'b0, 1'b0, 1'b0);
        send_word(4'h9, 1'b0, 1'b0, 1'b0);
        chk("tp3_ovo", 32'(bus.OVO), 32'd1);
        chk("tp3_do3", 32'(bus.DO), 32'h3);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("tp3_do5", 32'(bus.DO), 32'h5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("tp3_empty", 32'(bus.DVO), 32'd0);

        // Full FIFO with a pop on the cycle the third word completes.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        send_word(4'h3, 1'b1, 1'b0, 1'b0);
        send_word(4'h5, 1'b0, 1'b0, 1'b0);
        send_word(4'h9, 1'b0, 1'b0, 1'b1);
        chk("tp4_ovo", 32'(bus.OVO), 32'd0);
        chk("tp4_do5", 32'(bus.DO), 32'h5);
        cyc(1'b0, 1'b0, 1'b0, 1'b1);
        chk("tp4_do9", 32'(bus.DO), 32'h9);

        // FI mid-word: two bits, then restart with 0,1,1,1 -> E.
        cyc(1'b1, 1'b0, 1'b0, 1'b0);
        cyc(1'b0, 1'b1, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        chk("tp5_nopart", 32'(bus.DVO), 32'd0);
        send_word(4'hE, 1'b1, 1'b0, 1'b0);
        chk("tp5_feo", 32'(bus.FEO), 32'd1);
        chk("tp5_do", 32'(bus.DO), 32'hE);

        // Reset mid-operation (one word buffered, two bits collected).
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b0, 1'b0, 1'b1, 1'b0);
        cyc(1'b1, 1'b1, 1'b1, 1'b1);
        chk("tp6_dvo", 32'(bus.DVO), 32'd0);
        chk("tp6_feo", 32'(bus.FEO), 32'd0);
        for (int i = 0; i < 8; i++) cyc(1'b0, 1'b0, 1'b1, 1'b1);
        chk("tp6_noword", 32'(bus.DVO), 32'd0);

        // Randomized traffic with phases of heavy and light backpressure.
        for (int i = 0; i < 3000; i++) begin
            bit ri;
            bit fi;
            bit dri;
            ri  = ($urandom_range(0, 299) == 0);
            fi  = ($urandom_range(0, 9) == 0);
            if (((i / 200) % 2) == 0) dri = ($urandom_range(0, 3) != 0);
            else dri = ($urandom_range(0, 3) == 0);
            cyc(ri, fi, 1'($urandom_range(0, 1)), dri);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
